contador_checker: RTL and testbench

- Downstream consumer of two modulo-15 counter outputs driven from the same clock and reset.
- Samples both 4-bit counts and checks that each advances legally (n -> n+1, 14 -> 0).
- Checks that the two counts agree, counts legal wrap-arounds, and latches a sticky fault.
- Sits beside the counters in the test/integration environment as a self-checking monitor usable in RTL and on silicon debug pins.

---
 rtl/contador_checker.sv | 123 ++++++++++++
 tb/tb_contador_checker.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/contador_checker.sv
// Monitor for two modulo-MOD counters: checks each advances legally, that they agree,
// counts legal A wrap-arounds and latches a sticky fault with a per-counter error code.
module contador_checker #(
    parameter int MOD    = 15,
    parameter int WRAP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [3:0]        cont_a,
    input  logic [3:0]        cont_b,
    output logic [1:0]        state,
    output logic              locked,
    output logic              mismatch,
    output logic              seq_err,
    output logic [1:0]        err_code,
    output logic [WRAP_W-1:0] wraps
);

    typedef enum logic [1:0] {
        SYNC  = 2'b00,
        TRACK = 2'b01,
        FAULT = 2'b10
    } state_t;

    localparam logic [3:0] LAST = 4'(MOD - 1);

    state_t            state_q, state_d;
    logic              locked_q, locked_d;
    logic              mismatch_q, mismatch_d;
    logic              seq_err_q, seq_err_d;
    logic [1:0]        err_code_q, err_code_d;
    logic [WRAP_W-1:0] wraps_q, wraps_d;
    logic [3:0]        prev_a_q, prev_a_d;
    logic [3:0]        prev_b_q, prev_b_d;
    logic              bad_a, bad_b;

    function automatic logic is_legal(input logic [3:0] v);
        return {1'b0, v} < 5'(MOD);
    endfunction

    function automatic logic [3:0] exp_next(input logic [3:0] p);
        return (p == LAST) ? 4'd0 : p + 4'd1;
    endfunction

    // A hold (cont == prev) also counts as bad: en is expected to mark every advance.
    always_comb begin
        bad_a = !is_legal(cont_a) || (cont_a != exp_next(prev_a_q));
        bad_b = !is_legal(cont_b) || (cont_b != exp_next(prev_b_q));
    end

    always_comb begin
        state_d    = state_q;
        locked_d   = locked_q;
        mismatch_d = 1'b0;
        seq_err_d  = seq_err_q;
        err_code_d = err_code_q;
        wraps_d    = wraps_q;
        prev_a_d   = prev_a_q;
        prev_b_d   = prev_b_q;
        if (en) begin
            case (state_q)
                SYNC: begin
                    if (cont_a == cont_b && is_legal(cont_a)) begin
                        state_d  = TRACK;
                        locked_d = 1'b1;
                        prev_a_d = cont_a;
                        prev_b_d = cont_b;
                    end
                end
                TRACK: begin
                    mismatch_d = (cont_a != cont_b);
                    if (bad_a || bad_b) begin
                        state_d    = FAULT;
                        locked_d   = 1'b0;
                        seq_err_d  = 1'b1;
                        err_code_d = {bad_b, bad_a};
                    end else begin
                        prev_a_d = cont_a;
                        prev_b_d = cont_b;
                        if (prev_a_q == LAST && cont_a == 4'd0 && wraps_q != '1)
                            wraps_d = wraps_q + 1'b1;
                    end
                end
                FAULT: ;
                default: begin
                    state_d  = SYNC;
                    locked_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= SYNC;
            locked_q   <= 1'b0;
            mismatch_q <= 1'b0;
            seq_err_q  <= 1'b0;
            err_code_q <= 2'b00;
            wraps_q    <= '0;
            prev_a_q   <= 4'd0;
            prev_b_q   <= 4'd0;
        end else begin
            state_q    <= state_d;
            locked_q   <= locked_d;
            mismatch_q <= mismatch_d;
            seq_err_q  <= seq_err_d;
            err_code_q <= err_code_d;
            wraps_q    <= wraps_d;
            prev_a_q   <= prev_a_d;
            prev_b_q   <= prev_b_d;
        end
    end

    assign state    = state_q;
    assign locked   = locked_q;
    assign mismatch = mismatch_q;
    assign seq_err  = seq_err_q;
    assign err_code = err_code_q;
    assign wraps    = wraps_q;

endmodule

// File: tb/tb_contador_checker.sv
// Directed bench for contador_checker: a vector table plus hand-written counting,
// wrap-saturation and reset sequences. A second instance uses WRAP_W=2 for saturation.
module tb_contador_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [3:0] cont_a = 4'd0;
    logic [3:0] cont_b = 4'd0;

    logic [1:0] state, state2;
    logic       locked, locked2, mm, mm2, seq_err, seq_err2;
    logic [1:0] err_code, err_code2;
    logic [7:0] wraps;
    logic [1:0] wraps2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    contador_checker #(.MOD(15), .WRAP_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .cont_a(cont_a), .cont_b(cont_b),
        .state(state), .locked(locked), .mismatch(mm), .seq_err(seq_err),
        .err_code(err_code), .wraps(wraps)
    );

    contador_checker #(.MOD(15), .WRAP_W(2)) dut2 (
        .clk(clk), .rst(rst), .en(en), .cont_a(cont_a), .cont_b(cont_b),
        .state(state2), .locked(locked2), .mismatch(mm2), .seq_err(seq_err2),
        .err_code(err_code2), .wraps(wraps2)
    );

    typedef struct {
        logic       rst;
        logic       en;
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] st;
        logic       lk;
        logic       mm;
        logic       se;
        logic [1:0] ec;
        int         wr;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic e, input int a, input int b,
                       input int st, input int lk, input int m, input int se,
                       input int ec, input int wr);
        vec_t v;
        v.rst = r; v.en = e; v.a = 4'(a); v.b = 4'(b);
        v.st = 2'(st); v.lk = lk[0]; v.mm = m[0]; v.se = se[0]; v.ec = 2'(ec); v.wr = wr;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Drive inputs away from the edge, then sample #1 after the rising edge.
    task automatic step(input logic r, input logic e, input int a, input int b);
        rst = r; en = e; cont_a = 4'(a); cont_b = 4'(b);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input int st, input int lk, input int m,
                           input int se, input int ec, input int wr);
        chk({tag, ".state"}, int'(state), st);
        chk({tag, ".locked"}, int'(locked), lk);
        chk({tag, ".pulse"}, int'(mm), m);
        chk({tag, ".seq_err"}, int'(seq_err), se);
        chk({tag, ".err_code"}, int'(err_code), ec);
        chk({tag, ".wraps"}, int'(wraps), wr);
    endtask

    initial begin
        // reset, lock after settling
        add(1, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        add(0, 1, 3, 5,  0, 0, 0, 0, 0, 0);
        add(0, 1, 6, 6,  1, 1, 0, 0, 0, 0);
        add(0, 1, 7, 7,  1, 1, 0, 0, 0, 0);
        // skip on A, then frozen
        add(0, 1, 9, 8,  2, 0, 1, 1, 1, 0);
        add(0, 1, 10, 9, 2, 0, 0, 1, 1, 0);
        add(0, 1, 3, 3,  2, 0, 0, 1, 1, 0);
        add(0, 1, 15, 0, 2, 0, 0, 1, 1, 0);
        add(0, 0, 1, 2,  2, 0, 0, 1, 1, 0);
        add(0, 1, 0, 0,  2, 0, 0, 1, 1, 0);
        // reset out of FAULT, then en gaps while tracking
        add(1, 1, 4, 4,  0, 0, 0, 0, 0, 0);
        add(0, 1, 4, 4,  1, 1, 0, 0, 0, 0);
        add(0, 0, 9, 2,  1, 1, 0, 0, 0, 0);
        add(0, 0, 15, 15, 1, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0,  1, 1, 0, 0, 0, 0);
        add(0, 0, 4, 4,  1, 1, 0, 0, 0, 0);
        add(0, 0, 7, 3,  1, 1, 0, 0, 0, 0);
        add(0, 1, 5, 5,  1, 1, 0, 0, 0, 0);
        // hold is a fault on both; mismatch stays low because a==b
        add(0, 1, 5, 5,  2, 0, 0, 1, 3, 0);
        // B-only skip with mismatch
        add(1, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        add(0, 1, 2, 2,  1, 1, 0, 0, 0, 0);
        add(0, 1, 3, 5,  2, 0, 1, 1, 2, 0);

        #1;
        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].en, int'(tbl[i].a), int'(tbl[i].b));
            chk_all($sformatf("vec%0d", i), int'(tbl[i].st), int'(tbl[i].lk),
                    int'(tbl[i].mm), int'(tbl[i].se), int'(tbl[i].ec), tbl[i].wr);
        end

        // normal counting: 40 samples 0..14 repeating, then an illegal value on both
        begin
            int wr = 0;
            step(1, 0, 0, 0);
            step(1, 0, 0, 0);
            for (int i = 0; i < 40; i++) begin
                if (i > 0 && (i % 15) == 0) wr++;
                step(0, 1, i % 15, i % 15);
                chk_all($sformatf("count%0d", i), 1, 1, 0, 0, 0, wr);
            end
            chk("count.wraps_final", int'(wraps), 2);
            for (int v = 10; v <= 14; v++) begin
                step(0, 1, v, v);
                chk_all($sformatf("to14_%0d", v), 1, 1, 0, 0, 0, 2);
            end
            step(0, 1, 15, 15);
            chk_all("illegal_both", 2, 0, 0, 1, 3, 2);
        end

        // saturation on the 2-bit instance, then reset mid-count and re-lock
        begin
            int wr2 = 0;
            step(1, 0, 0, 0);
            for (int i = 0; i <= 75; i++) begin
                if (i > 0 && (i % 15) == 0 && wr2 < 3) wr2++;
                step(0, 1, i % 15, i % 15);
                chk($sformatf("sat%0d.wraps2", i), int'(wraps2), wr2);
            end
            chk("sat.wraps2_final", int'(wraps2), 3);
            chk("sat.wraps8_final", int'(wraps), 5);
            chk("sat.state2", int'(state2), 1);
            step(0, 1, 1, 1);
            step(1, 1, 2, 2);
            chk("rst_mid.state", int'(state), 0);
            chk("rst_mid.wraps", int'(wraps), 0);
            chk("rst_mid.wraps2", int'(wraps2), 0);
            chk("rst_mid.locked2", int'(locked2), 0);
            step(0, 1, 7, 7);
            chk("relock.state2", int'(state2), 1);
            chk("relock.locked2", int'(locked2), 1);
            chk("relock.seq_err2", int'(seq_err2), 0);
            chk("relock.err_code2", int'(err_code2), 0);
            chk("relock.pulse2", int'(mm2), 0);
            chk("relock.state", int'(state), 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
